// File: rtl/fu_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro DIV_FAST_PATH_EN: skip iteration when the divisor is zero or exceeds the dividend.
module fu_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [1:0]  op,
    input  logic [4:0]  rd,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        busy,
    output logic        finish,
    output logic [4:0]  Wt_addr_DIV,
    output logic [31:0] Wt_data_DIV,
    output logic        L_S_DIV
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [4:0]  rd_q, rd_d;
    logic        rem_sel_q, rem_sel_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        divz_q, divz_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial;
    logic [31:0] result;

    function automatic logic [31:0] magnitude(input logic [31:0] val, input logic neg);
        return neg ? (~val + 32'd1) : val;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] val, input logic neg);
        return neg ? (~val + 32'd1) : val;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        rd_d      = rd_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        divz_d    = divz_q;

        a_neg = ~op[0] & rs1_data[31];
        b_neg = ~op[0] & rs2_data[31];
        a_mag = magnitude(rs1_data, a_neg);
        b_mag = magnitude(rs2_data, b_neg);
        // Shift the next dividend bit into rem and trial-subtract in one 33-bit step
        trial = {rem_q, quo_q[31]} - {1'b0, div_q};

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    rd_d      = rd;
                    rem_sel_d = op[1];
                    qneg_d    = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    divz_d    = (b_mag == 32'd0);
                    div_d     = b_mag;
                    rem_d     = 32'd0;
                    quo_d     = a_mag;
                    cnt_d     = 6'd0;
                    state_d   = S_CALC;
`ifdef DIV_FAST_PATH_EN
                    if (b_mag == 32'd0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = a_mag;
                        state_d = S_DONE;
                    end else if (a_mag < b_mag) begin
                        quo_d   = 32'd0;
                        rem_d   = a_mag;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        div_q     <= div_d;
        rd_q      <= rd_d;
        rem_sel_q <= rem_sel_d;
        qneg_q    <= qneg_d;
        rneg_q    <= rneg_d;
        divz_q    <= divz_d;
    end

    // With a zero divisor rem holds |dividend|, so restoring the dividend sign returns it unmodified
    always_comb begin
        if (rem_sel_q) begin
            result = apply_sign(rem_q, rneg_q);
        end else if (divz_q) begin
            result = quo_q;
        end else begin
            result = apply_sign(quo_q, qneg_q);
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign finish      = (state_q == S_DONE);
    assign Wt_addr_DIV = finish ? rd_q : 5'd0;
    assign Wt_data_DIV = finish ? result : 32'd0;
    assign L_S_DIV     = finish & (rd_q != 5'd0);

endmodule

// File: tb/tb_fu_div_iter.sv
// Bench for fu_div_iter: vector table, scoreboard on the write-back port, and multi-cycle corner sequences.
module tb_fu_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        finish;
    logic [4:0]  Wt_addr_DIV;
    logic [31:0] Wt_data_DIV;
    logic        L_S_DIV;

    fu_div_iter dut (
        .clk(clk), .rst(rst), .EN(EN), .op(op), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .busy(busy), .finish(finish),
        .Wt_addr_DIV(Wt_addr_DIV), .Wt_data_DIV(Wt_data_DIV), .L_S_DIV(L_S_DIV)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
    } sb_t;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm;
        am = (!o[0] && a[31]) ? -a : a;
        bm = (!o[0] && b[31]) ? -b : b;
        return (bm == 32'd0) || (am < bm);
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
        return is_fast(o, a, b) ? 1 : 33;
`else
        return (is_fast(o, a, b) && 1'b0) ? 1 : 33;
`endif
    endfunction

    // Scoreboard consumer: every finish pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (finish === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish actual=1 required=0 data=%h", Wt_data_DIV);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("wb_data", Wt_data_DIV, e.data);
                chk("wb_addr", {27'd0, Wt_addr_DIV}, {27'd0, e.addr});
                chk("wb_we", {31'd0, L_S_DIV}, {31'd0, e.we});
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic [4:0] r, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("idle_before_issue", {31'd0, busy}, 32'd0);
        EN = 1'b1; op = o; rd = r; rs1_data = a; rs2_data = b;
        @(posedge clk);
        #1 EN = 1'b0;
    endtask

    task automatic wait_done(input int lat, input int poke);
        int  k;
        bit  got;
        got = 1'b0;
        k = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            k = i;
            chk("busy_during_op", {31'd0, busy}, 32'd1);
            if (i == poke) begin
                EN = 1'b1; op = OP_DIVU; rs1_data = 32'd1000; rs2_data = 32'd1;
            end
            if (i == poke + 1) EN = 1'b0;
            if (finish === 1'b1) got = 1'b1;
        end
        EN = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=no_finish required=finish_within_40");
        end else begin
            chk("latency", k, lat);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [4:0] r, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int poke);
        sb.push_back('{data: exp, addr: r, we: (r != 5'd0)});
        drive(o, r, a, b);
        wait_done(exp_latency(o, a, b), poke);
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{OP_DIV,  5'd5,  32'd100,        32'd7,          32'd14};
        vecs[1]  = '{OP_REM,  5'd3,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[2]  = '{OP_REMU, 5'd3,  32'hFFFF_FFF9,  32'd2,          32'd1};
        vecs[3]  = '{OP_DIV,  5'd7,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[4]  = '{OP_REM,  5'd7,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[5]  = '{OP_DIVU, 5'd9,  32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[6]  = '{OP_REMU, 5'd9,  32'd5,          32'd0,          32'd5};
        vecs[7]  = '{OP_DIVU, 5'd10, 32'd3,          32'd10,         32'd0};
        vecs[8]  = '{OP_DIV,  5'd11, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};
        vecs[9]  = '{OP_DIV,  5'd12, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[10] = '{OP_REM,  5'd13, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[11] = '{OP_DIVU, 5'd14, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[12] = '{OP_REM,  5'd15, 32'd100,        32'hFFFF_FFF9,  32'd2};
        vecs[13] = '{OP_REM,  5'd16, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};
        vecs[14] = '{OP_DIV,  5'd17, 32'd0,          32'd5,          32'd0};
        vecs[15] = '{OP_REMU, 5'd31, 32'd3,          32'd10,         32'd3};

        rst = 1'b1; EN = 1'b0; op = 2'b00; rd = 5'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_finish", {31'd0, finish}, 32'd0);
        chk("reset_addr", {27'd0, Wt_addr_DIV}, 32'd0);
        chk("reset_data", Wt_data_DIV, 32'd0);
        chk("reset_we", {31'd0, L_S_DIV}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 16; v++) begin
            run_op(vecs[v].op, vecs[v].rd, vecs[v].a, vecs[v].b, vecs[v].exp, 0);
        end

        // rd=0 with a stray EN and operand change mid-CALC, then an immediate back-to-back issue
        run_op(OP_DIV, 5'd0, 32'd9, 32'd3, 32'd3, 10);
        run_op(OP_DIV, 5'd1, 32'd21, 32'd7, 32'd3, 0);

        // Abort mid-CALC: reset in cycle T+15, nothing may be written back for that op
        drive(OP_DIV, 5'd4, 32'd50, 32'd5);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 15) rst = 1'b1;
        end
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_finish", {31'd0, finish}, 32'd0);
        chk("abort_addr", {27'd0, Wt_addr_DIV}, 32'd0);
        chk("abort_data", Wt_data_DIV, 32'd0);
        chk("abort_we", {31'd0, L_S_DIV}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (finish === 1'b1) seen = 1'b1;
        end
        chk("abort_no_finish", {31'd0, seen}, 32'd0);

        run_op(OP_DIV, 5'd2, 32'd8, 32'd2, 32'd4, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_div_iter.md
# fu_div_iter

Iterative 32-bit integer divide functional unit for the scoreboard core. It accepts one RV32M divide/remainder instruction when issued and computes it with a radix-2 restoring divider, one quotient bit per cycle. It returns the result on the DIV write-back port of the multi-port register file (Wt_addr_DIV / Wt_data_DIV / L_S_DIV). Operands come from that register file's DIV read ports, rdata_A_DIV and rdata_B_DIV.

## Interface
Parameters
- none

Ports
- clk  input  1  core clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- EN  input  1  issue strobe from scoreboard; sampled only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rd  input  5  destination register
- rs1_data  input  32  dividend, from rdata_A_DIV
- rs2_data  input  32  divisor, from rdata_B_DIV
- busy  output  1  high from the cycle after accept until the DONE cycle inclusive
- finish  output  1  one-cycle pulse in DONE; scoreboard clears the DIV FU status on it
- Wt_addr_DIV  output  5  latched rd, valid when finish=1, else 0
- Wt_data_DIV  output  32  result, valid when finish=1, else 0
- L_S_DIV  output  1  write enable = finish and (latched rd != 0)

## Operation
- States: IDLE, CALC, DONE.
- IDLE, EN=1: latch op, rd, the operand magnitudes, and the sign flags, then go to CALC. Signed ops (DIV, REM) take the absolute value of each operand. Unsigned ops take the operands as-is.
- IDLE, EN=0: stay in IDLE.
- CALC:
  - 6-bit counter runs 0..31.
  - Each cycle: shift {rem, quo} left by one, then trial-subtract the divisor magnitude from rem.
  - If the 33-bit result is non-negative, keep the difference and set quo[0]=1.
  - After the iteration with count=31, go to DONE.
- DONE:
  - Assert finish and drive the result for one cycle, then go to IDLE.
  - A new EN is accepted no earlier than the cycle after DONE.
- Sign fix-up, applied when forming the result:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero, all ops: quotient = 0xFFFFFFFF; remainder = dividend unmodified. The iterations produce this naturally for unsigned ops. For signed ops the sign fix-up is bypassed.
- Signed overflow, DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This must come from the normal datapath (magnitude 2^31 / 1, then negate).
- rd = 0: full latency and finish pulse still occur, but L_S_DIV = 0.
- EN while busy: ignored. The scoreboard must not issue to a busy FU; this block does not queue.
- Operands are captured only at accept. Later changes on rs1_data/rs2_data have no effect.

## Timing
- Reset values: state IDLE, busy 0, finish 0, Wt_addr_DIV 0, Wt_data_DIV 0, L_S_DIV 0, counter 0.
- Accept in cycle T (EN=1 at the posedge ending T while in IDLE):
  - CALC occupies cycles T+1..T+32.
  - DONE is cycle T+33: finish=1, outputs valid.
  - IDLE again at T+34.
- Latency is 33 cycles from accept to finish.
- The register file writes on negedge, so the write lands inside the DONE cycle.
- Back-to-back issue: the earliest second accept is in cycle T+34.
- rst=1 at any posedge, including mid-CALC or in DONE: next cycle is IDLE with all outputs 0. No write-back or finish is produced for the aborted operation.
- The fast path (Configuration) shortens CALC; DONE timing is otherwise unchanged.

## Configuration
- Macro: DIV_FAST_PATH_EN.
- Defined: at accept, if the divisor magnitude is 0, or the unsigned dividend magnitude is less than the divisor magnitude, go straight to DONE at T+1 (latency 1).
  - Result in the magnitude-less-than case: quotient 0, remainder = dividend.
  - Divide-by-zero results are as specified in Operation.
- Undefined: every operation takes the full 33-cycle latency.
- Result values are identical in both builds.

## Test plan
- Reset, then DIV 100 / 7 into rd=5: finish at T+33; Wt_data_DIV=14, Wt_addr_DIV=5, L_S_DIV=1; busy high T+1..T+33.
- REM 0xFFFFFFF9 (-7) / 2 into rd=3: result 0xFFFFFFFF (-1). REMU with the same operands: result 1.
- DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM with the same operands: 0. DIVU 5 / 0: 0xFFFFFFFF. REMU 5 / 0: 5.
- DIV 9 / 3 with rd=0: finish pulses, L_S_DIV=0. EN pulsed at T+10 (busy) is ignored. A new issue at T+34 is accepted.
- rst asserted at T+15 mid-CALC: all outputs 0 from T+16; no finish ever appears for that op. A following DIV 8 / 2 yields 4.
- DIVU 3 / 10: with DIV_FAST_PATH_EN, finish at T+1 with result 0; without it, finish at T+33 with result 0.
